// File: rtl/matmul_job_sequencer.sv
// Job-level sequencer for the systolic matmul tile: accepts and validates one command,
// derives the pre-divided size operands, and times control-block reset, run and drain.
module matmul_job_sequencer #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12,
    parameter int DRAIN_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [MATRIXSIZE_W-1:0] cmd_m1,
    input  logic [MATRIXSIZE_W-1:0] cmd_m2,
    input  logic [MATRIXSIZE_W-1:0] cmd_m3,
    input  logic                    abort,
    output logic                    ctrl_rst,
    output logic [MATRIXSIZE_W-1:0] M2,
    output logic [MATRIXSIZE_W-1:0] M1dN1,
    output logic [MATRIXSIZE_W-1:0] M3dN2,
    output logic [MATRIXSIZE_W-1:0] M1xM3dN1xN2,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    err,
    output logic [2:0]              err_code
);
    localparam int MW        = MATRIXSIZE_W;
    localparam int PW        = 2 * MATRIXSIZE_W;
    localparam int LOG_N1    = $clog2(N1);
    localparam int LOG_N2    = $clog2(N2);
    localparam int DRAIN_LEN = N1 + N2 + DRAIN_LAT;
    localparam int DW        = $clog2(DRAIN_LEN) + 1;

    localparam logic [MW-1:0] N1_MASK    = MW'(N1 - 1);
    localparam logic [MW-1:0] N2_MASK    = MW'(N2 - 1);
    localparam logic [PW:0]   A_LIMIT    = (PW + 1)'(1) << ADDR_W_A;
    localparam logic [PW:0]   B_LIMIT    = (PW + 1)'(1) << ADDR_W_B;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
    logic [MW-1:0] m2o_q, m2o_d, m1dn1_q, m1dn1_d, m3dn2_q, m3dn2_d, p_q, p_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [PW-1:0] run_total_q, run_total_d, run_cntr_q, run_cntr_d;
    logic [DW-1:0] drain_cntr_q, drain_cntr_d;
    logic          aborted_q, aborted_d;

    logic [MW-1:0] m1_div, m3_div;
    logic [PW-1:0] p_full, a_words, b_words;
    logic [2:0]    load_code;

    // Validation of the latched command; the lowest-numbered failing check is reported.
    always_comb begin
        m1_div  = m1_q >> LOG_N1;
        m3_div  = m3_q >> LOG_N2;
        p_full  = {{MW{1'b0}}, m1_div} * {{MW{1'b0}}, m3_div};
        a_words = {{MW{1'b0}}, m1_div} * {{MW{1'b0}}, m2_q};
        b_words = {{MW{1'b0}}, m3_div} * {{MW{1'b0}}, m2_q};
        load_code = 3'd0;
        if ((m1_q == '0) || (m2_q == '0) || (m3_q == '0)) begin
            load_code = 3'd1;
        end else if ((m1_q & N1_MASK) != '0) begin
            load_code = 3'd2;
        end else if ((m3_q & N2_MASK) != '0) begin
            load_code = 3'd3;
        end else if (p_full[PW-1:MW] != '0) begin
            load_code = 3'd4;
        end else if ({1'b0, a_words} > A_LIMIT) begin
            load_code = 3'd5;
        end else if ({1'b0, b_words} > B_LIMIT) begin
            load_code = 3'd6;
        end
    end

    always_comb begin
        state_d      = state_q;
        m1_d         = m1_q;
        m2_d         = m2_q;
        m3_d         = m3_q;
        m2o_d        = m2o_q;
        m1dn1_d      = m1dn1_q;
        m3dn2_d      = m3dn2_q;
        p_d          = p_q;
        err_code_d   = err_code_q;
        run_total_d  = run_total_q;
        run_cntr_d   = run_cntr_q;
        drain_cntr_d = drain_cntr_q;
        aborted_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    m1_d       = cmd_m1;
                    m2_d       = cmd_m2;
                    m3_d       = cmd_m3;
                    err_code_d = 3'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                // Size outputs are captured here even on rejection so the host can inspect them.
                m2o_d   = m2_q;
                m1dn1_d = m1_div;
                m3dn2_d = m3_div;
                p_d     = p_full[MW-1:0];
                if (load_code != 3'd0) begin
                    err_code_d = load_code;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                run_total_d = {{MW{1'b0}}, p_q} * {{MW{1'b0}}, m2o_q};
                run_cntr_d  = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (run_cntr_q == run_total_q - PW'(1)) begin
                    drain_cntr_d = '0;
                    state_d      = S_DRAIN;
                end else begin
                    run_cntr_d = run_cntr_q + PW'(1);
                end
            end
            S_DRAIN: begin
                // Abort takes priority over completion on the final drain cycle.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (drain_cntr_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cntr_d = drain_cntr_q + DW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            m1_q         <= '0;
            m2_q         <= '0;
            m3_q         <= '0;
            m2o_q        <= '0;
            m1dn1_q      <= '0;
            m3dn2_q      <= '0;
            p_q          <= '0;
            err_code_q   <= '0;
            run_total_q  <= '0;
            run_cntr_q   <= '0;
            drain_cntr_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            m1_q         <= m1_d;
            m2_q         <= m2_d;
            m3_q         <= m3_d;
            m2o_q        <= m2o_d;
            m1dn1_q      <= m1dn1_d;
            m3dn2_q      <= m3dn2_d;
            p_q          <= p_d;
            err_code_q   <= err_code_d;
            run_total_q  <= run_total_d;
            run_cntr_q   <= run_cntr_d;
            drain_cntr_q <= drain_cntr_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ctrl_rst    = !((state_q == S_RUN) || (state_q == S_DRAIN));
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_ERR);
    assign aborted     = aborted_q;
    assign err_code    = err_code_q;
    assign M2          = m2o_q;
    assign M1dN1       = m1dn1_q;
    assign M3dN2       = m3dn2_q;
    assign M1xM3dN1xN2 = p_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Bench for matmul_job_sequencer: expected job outcomes are queued at command accept
// and matched against the done/err/aborted pulses as they appear.
`timescale 1ns/1ps
module tb_matmul_job_sequencer;
    localparam int N1 = 4, N2 = 4, MW = 16, AWA = 12, AWB = 12, DL = 2;
    localparam int K_DONE = 1, K_ERR = 2, K_ABORT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic abort = 1'b0;
    logic [MW-1:0] cmd_m1 = '0, cmd_m2 = '0, cmd_m3 = '0;
    logic cmd_ready, ctrl_rst, busy, done, aborted, err;
    logic [MW-1:0] M2, M1dN1, M3dN2, M1xM3dN1xN2;
    logic [2:0] err_code;
    logic [4*MW-1:0] sizes_o;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int kind;
        int code;
        int at;
        logic [4*MW-1:0] sizes;
    } exp_t;
    exp_t exp_q[$];

    matmul_job_sequencer #(
        .N1(N1), .N2(N2), .MATRIXSIZE_W(MW), .ADDR_W_A(AWA), .ADDR_W_B(AWB), .DRAIN_LAT(DL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m1(cmd_m1), .cmd_m2(cmd_m2), .cmd_m3(cmd_m3), .abort(abort),
        .ctrl_rst(ctrl_rst), .M2(M2), .M1dN1(M1dN1), .M3dN2(M3dN2),
        .M1xM3dN1xN2(M1xM3dN1xN2), .busy(busy), .done(done), .aborted(aborted),
        .err(err), .err_code(err_code)
    );

    assign sizes_o = {M2, M1dN1, M3dN2, M1xM3dN1xN2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the command checks and job latency.
    task automatic push_exp(input int m1, input int m2, input int m3, input int c, input int abort_k);
        exp_t e;
        longint d1, d3, p, rt;
        int code;
        d1 = m1 / N1;
        d3 = m3 / N2;
        p  = d1 * d3;
        rt = p * m2;
        if (m1 == 0 || m2 == 0 || m3 == 0) code = 1;
        else if (m1 % N1 != 0) code = 2;
        else if (m3 % N2 != 0) code = 3;
        else if (p >= (longint'(1) << MW)) code = 4;
        else if (d1 * m2 > (longint'(1) << AWA)) code = 5;
        else if (d3 * m2 > (longint'(1) << AWB)) code = 6;
        else code = 0;
        e.code  = code;
        e.sizes = {MW'(m2), MW'(d1), MW'(d3), MW'(p)};
        if (code != 0) begin
            e.kind = K_ERR;
            e.at   = c + 2;
        end else if (abort_k >= 0) begin
            e.kind = K_ABORT;
            e.at   = c + abort_k + 1;
        end else begin
            e.kind = K_DONE;
            e.at   = c + 3 + int'(rt) + N1 + N2 + DL;
        end
        exp_q.push_back(e);
    endtask

    // Offers a command from the current negedge; returns at the negedge after accept.
    task automatic issue(input int m1, input int m2, input int m3, input int abort_k, output int c);
        cmd_m1 = MW'(m1);
        cmd_m2 = MW'(m2);
        cmd_m3 = MW'(m3);
        cmd_valid = 1'b1;
        c = -1;
        for (int i = 0; i < 50 && c < 0; i++) begin
            if (cmd_ready) c = cyc;
            else @(negedge clk);
        end
        if (c >= 0) push_exp(m1, m2, m3, c, abort_k);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Observes until the first outcome pulse, gathering ctrl_rst/busy/size-stability data.
    task automatic wait_event(input int limit, input int abort_cyc, output int kind, output int at,
                              output int lows, output int busy_n, output int chg);
        logic [4*MW-1:0] snap;
        logic prev_low;
        kind = 0; at = -1; lows = 0; busy_n = 0; chg = 0; prev_low = 1'b0; snap = '0;
        for (int i = 0; i < limit; i++) begin
            if (busy) busy_n++;
            if (!ctrl_rst) begin
                lows++;
                if (!prev_low) snap = sizes_o;
                else if (sizes_o !== snap) chg++;
            end
            prev_low = !ctrl_rst;
            if (done || err || aborted) begin
                kind = int'({aborted, err, done});
                at = cyc;
                break;
            end
            @(negedge clk);
            abort = (cyc == abort_cyc);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ctrl_rst !== 1'b1) begin n_fail++; $display("FAIL rst_ctrl_rst: got %b want 1", ctrl_rst); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if ({busy, done, err, aborted} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {busy, done, err, aborted}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (sizes_o !== '0) begin n_fail++; $display("FAIL rst_sizes: got %h want 0", sizes_o); end
        n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
        n_checks++; if ({cmd_ready, ctrl_rst, busy} !== 3'b110) begin n_fail++; $display("FAIL rst_release: got %b want 110", {cmd_ready, ctrl_rst, busy}); end
    endtask

    task automatic test_basic_job();
        int c, kind, at, lows, busy_n, chg;
        exp_t e;
        issue(8, 6, 8, -1, c);
        n_checks++; if (c < 0) begin n_fail++; $display("FAIL basic_accept: got no accept want accept"); end
        wait_event(200, -1, kind, at, lows, busy_n, chg);
        e = exp_q.pop_front();
        n_checks++; if (kind !== e.kind) begin n_fail++; $display("FAIL basic_kind: got %0d want %0d", kind, e.kind); end
        n_checks++; if (at - c !== 37) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 37", at - c); end
        n_checks++; if (at !== e.at) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", at, e.at); end
        n_checks++; if (lows !== 34) begin n_fail++; $display("FAIL basic_ctrl_low_cycles: got %0d want 34", lows); end
        n_checks++; if (busy_n !== 37) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 37", busy_n); end
        n_checks++; if (chg !== 0) begin n_fail++; $display("FAIL basic_size_stable: got %0d changes want 0", chg); end
        n_checks++; if (sizes_o !== e.sizes) begin n_fail++; $display("FAIL basic_sizes: got %h want %h", sizes_o, e.sizes); end
        @(negedge clk);
        n_checks++; if ({cmd_ready, busy, done} !== 3'b100) begin n_fail++; $display("FAIL basic_back_idle: got %b want 100", {cmd_ready, busy, done}); end
        n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL basic_err_code: got %0d want 0", err_code); end
    endtask

    task automatic test_errors();
        int tbl[7][3] = '{'{6, 6, 8}, '{4, 0, 4}, '{4, 4, 6}, '{1024, 1, 1024},
                          '{4096, 5, 4}, '{4, 2048, 12}, '{4096, 4, 4}};
        int c, kind, at, lows, busy_n, chg, want_lows;
        exp_t e;
        for (int t = 0; t < 7; t++) begin
            issue(tbl[t][0], tbl[t][1], tbl[t][2], -1, c);
            n_checks++; if (c < 0) begin n_fail++; $display("FAIL err%0d_accept: got no accept want accept", t); end
            wait_event(5000, -1, kind, at, lows, busy_n, chg);
            e = exp_q.pop_front();
            want_lows = (e.kind == K_DONE) ? (e.at - c - 3) : 0;
            n_checks++; if (kind !== e.kind) begin n_fail++; $display("FAIL err%0d_kind: got %0d want %0d", t, kind, e.kind); end
            n_checks++; if (at !== e.at) begin n_fail++; $display("FAIL err%0d_cycle: got %0d want %0d", t, at, e.at); end
            n_checks++; if (lows !== want_lows) begin n_fail++; $display("FAIL err%0d_ctrl_low: got %0d want %0d", t, lows, want_lows); end
            n_checks++; if (sizes_o !== e.sizes) begin n_fail++; $display("FAIL err%0d_sizes: got %h want %h", t, sizes_o, e.sizes); end
            @(negedge clk);
            n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err%0d_ready_after: got %b want 1", t, cmd_ready); end
            n_checks++; if (err_code !== 3'(e.code)) begin n_fail++; $display("FAIL err%0d_code: got %0d want %0d", t, err_code, e.code); end
        end
    endtask

    task automatic test_abort();
        int c, c2, kind, at, lows, busy_n, chg;
        exp_t e;
        issue(8, 6, 8, 12, c);
        wait_event(200, c + 12, kind, at, lows, busy_n, chg);
        e = exp_q.pop_front();
        n_checks++; if (kind !== e.kind) begin n_fail++; $display("FAIL abort_kind: got %0d want %0d", kind, e.kind); end
        n_checks++; if (at !== e.at) begin n_fail++; $display("FAIL abort_cycle: got %0d want %0d", at, e.at); end
        n_checks++; if (ctrl_rst !== 1'b1) begin n_fail++; $display("FAIL abort_ctrl_rst: got %b want 1", ctrl_rst); end
        n_checks++; if (lows !== 10) begin n_fail++; $display("FAIL abort_ctrl_low: got %0d want 10", lows); end
        issue(8, 6, 8, -1, c2);
        n_checks++; if (c2 !== e.at) begin n_fail++; $display("FAIL abort_reaccept: got %0d want %0d", c2, e.at); end
        wait_event(200, -1, kind, at, lows, busy_n, chg);
        e = exp_q.pop_front();
        n_checks++; if (kind !== e.kind) begin n_fail++; $display("FAIL abort_next_kind: got %0d want %0d", kind, e.kind); end
        n_checks++; if (at !== e.at) begin n_fail++; $display("FAIL abort_next_cycle: got %0d want %0d", at, e.at); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c, pulses;
        exp_t e;
        issue(8, 6, 8, -1, c);
        repeat (29) @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_back();
        n_checks++; if ({ctrl_rst, busy} !== 2'b01) begin n_fail++; $display("FAIL rmid_in_drain: got %b want 01", {ctrl_rst, busy}); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({ctrl_rst, cmd_ready, busy} !== 3'b110) begin n_fail++; $display("FAIL rmid_async: got %b want 110", {ctrl_rst, cmd_ready, busy}); end
        n_checks++; if ({done, err, aborted} !== 3'b000) begin n_fail++; $display("FAIL rmid_pulses: got %b want 000", {done, err, aborted}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (sizes_o !== '0) begin n_fail++; $display("FAIL rmid_sizes: got %h want 0", sizes_o); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", cmd_ready); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || aborted || err || !ctrl_rst) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d activity cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int jobs[3][3] = '{'{8, 6, 8}, '{4, 2, 8}, '{16, 1, 4}};
        int accepts, ready_seen, events, gap, min_gap, chg;
        logic prev_low;
        logic [4*MW-1:0] snap;
        exp_t e;
        accepts = 0; ready_seen = 0; events = 0; gap = 0; min_gap = 1000; chg = 0;
        prev_low = 1'b0; snap = '0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300 && events < 3; i++) begin
            if (done || err || aborted) begin
                events++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_unexpected: got outcome %b want none", {aborted, err, done});
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (int'({aborted, err, done}) !== e.kind) begin n_fail++; $display("FAIL b2b_kind: got %0d want %0d", int'({aborted, err, done}), e.kind); end
                    n_checks++; if (cyc !== e.at) begin n_fail++; $display("FAIL b2b_cycle: got %0d want %0d", cyc, e.at); end
                    n_checks++; if (sizes_o !== e.sizes) begin n_fail++; $display("FAIL b2b_sizes: got %h want %h", sizes_o, e.sizes); end
                end
            end
            if (!ctrl_rst) begin
                if (!prev_low) begin
                    snap = sizes_o;
                    if (accepts > 1 && gap < min_gap) min_gap = gap;
                end else if (sizes_o !== snap) begin
                    chg++;
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_low = !ctrl_rst;
            if (cmd_ready) ready_seen++;
            if (cmd_ready && accepts < 3) begin
                cmd_m1 = MW'(jobs[accepts][0]);
                cmd_m2 = MW'(jobs[accepts][1]);
                cmd_m3 = MW'(jobs[accepts][2]);
                push_exp(jobs[accepts][0], jobs[accepts][1], jobs[accepts][2], cyc, -1);
                accepts++;
            end else begin
                cmd_m1 = MW'($urandom);
                cmd_m2 = MW'($urandom);
                cmd_m3 = MW'($urandom);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++; if (events !== 3) begin n_fail++; $display("FAIL b2b_events: got %0d want 3", events); end
        n_checks++; if (ready_seen !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", ready_seen); end
        n_checks++; if (chg !== 0) begin n_fail++; $display("FAIL b2b_size_stable: got %0d changes want 0", chg); end
        n_checks++; if (min_gap !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d want 4", min_gap); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
